// File: rtl/alu_operand_responder_if.sv
// Operand-request / operand-response handshake bundle between the ALU issue
// stage (master) and the operand responder (slave).
interface alu_operand_responder_if;
  logic        i_ReqDrive_1;
  logic        o_ReqFree_1;
  logic [4:0]  i_ReqRs1_5;
  logic [4:0]  i_ReqRs2_5;
  logic [3:0]  i_ReqDepL_4;
  logic [3:0]  i_ReqDepR_4;
  logic        o_RspDrive_1;
  logic        i_RspFree_1;
  logic [31:0] o_OperandL_32;
  logic [31:0] o_OperandR_32;
  logic        o_SrcL_1;
  logic        o_SrcR_1;

  modport master (
    output i_ReqDrive_1, i_ReqRs1_5, i_ReqRs2_5, i_ReqDepL_4, i_ReqDepR_4, i_RspFree_1,
    input  o_ReqFree_1, o_RspDrive_1, o_OperandL_32, o_OperandR_32, o_SrcL_1, o_SrcR_1
  );

  modport slave (
    input  i_ReqDrive_1, i_ReqRs1_5, i_ReqRs2_5, i_ReqDepL_4, i_ReqDepR_4, i_RspFree_1,
    output o_ReqFree_1, o_RspDrive_1, o_OperandL_32, o_OperandR_32, o_SrcL_1, o_SrcR_1
  );
endinterface

// File: rtl/alu_operand_responder.sv
// ALU operand responder: owns the 32x32 GRF and the 16-entry bypass buffer,
// resolves left/right operands per request and returns them as a pair.
// Optional feature macro: ALU_RSP_TIMEOUT_EN (sticky wait-timeout flag).
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | request accepted, at least one side waiting on a bypass entry
// RESP  | operand pair presented, held until the issue stage takes it
module alu_operand_responder (
  input  logic                     clk,
  input  logic                     rstn,
  alu_operand_responder_if.slave   opBus,
  input  logic                     i_GrfWe_1,
  input  logic [4:0]               i_GrfWaddr_5,
  input  logic [31:0]              i_GrfWdata_32,
  input  logic                     i_BypWe_1,
  input  logic [3:0]               i_BypTag_4,
  input  logic [31:0]              i_BypData_32,
  input  logic                     i_BypRel_1,
  input  logic [3:0]               i_BypRelTag_4,
  output logic                     o_Timeout_1
);

  localparam logic [3:0] NoDep = 4'hF;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, stateNext;
  logic [31:0] grf [32];
  logic [31:0] bypData [16];
  logic [15:0] bypValid;

  logic        pendL, pendR;
  logic [3:0]  tagL, tagR;
  logic [31:0] operandL, operandR;
  logic        srcL, srcR;

  logic        reqFree, accept;
  logic [31:0] grfRd1, grfRd2;
  logic [3:0]  lookTagL, lookTagR;
  logic        hitL, hitR;
  logic [31:0] bypRdL, bypRdR;
  logic        resL, resR;
  logic [31:0] valL, valR;

  // GRF read ports; a same-cycle write to the read index is forwarded
  always_comb begin
    grfRd1 = 32'd0;
    grfRd2 = 32'd0;
    if (opBus.i_ReqRs1_5 != 5'd0) begin
      if (i_GrfWe_1 && (i_GrfWaddr_5 == opBus.i_ReqRs1_5)) grfRd1 = i_GrfWdata_32;
      else                                                 grfRd1 = grf[opBus.i_ReqRs1_5];
    end
    if (opBus.i_ReqRs2_5 != 5'd0) begin
      if (i_GrfWe_1 && (i_GrfWaddr_5 == opBus.i_ReqRs2_5)) grfRd2 = i_GrfWdata_32;
      else                                                 grfRd2 = grf[opBus.i_ReqRs2_5];
    end
  end

  // Bypass lookup per side: stored tag while waiting, request tag otherwise
  always_comb begin
    lookTagL = (state == WAIT) ? tagL : opBus.i_ReqDepL_4;
    lookTagR = (state == WAIT) ? tagR : opBus.i_ReqDepR_4;
    hitL     = 1'b0;
    hitR     = 1'b0;
    bypRdL   = bypData[lookTagL];
    bypRdR   = bypData[lookTagR];
    if (lookTagL != NoDep) begin
      if (i_BypWe_1 && (i_BypTag_4 == lookTagL)) begin
        hitL   = 1'b1;
        bypRdL = i_BypData_32;
      end else if (bypValid[lookTagL]) begin
        hitL = 1'b1;
      end
    end
    if (lookTagR != NoDep) begin
      if (i_BypWe_1 && (i_BypTag_4 == lookTagR)) begin
        hitR   = 1'b1;
        bypRdR = i_BypData_32;
      end else if (bypValid[lookTagR]) begin
        hitR = 1'b1;
      end
    end
  end

  // Resolution of a newly presented request
  always_comb begin
    resL = (opBus.i_ReqDepL_4 == NoDep) || hitL;
    resR = (opBus.i_ReqDepR_4 == NoDep) || hitR;
    valL = (opBus.i_ReqDepL_4 == NoDep) ? grfRd1 : bypRdL;
    valR = (opBus.i_ReqDepR_4 == NoDep) ? grfRd2 : bypRdR;
  end

  // Next-state and request-acceptance logic
  always_comb begin
    stateNext = state;
    reqFree   = rstn && ((state == IDLE) || ((state == RESP) && opBus.i_RspFree_1));
    accept    = reqFree && opBus.i_ReqDrive_1;
    case (state)
      IDLE: if (accept) stateNext = (resL && resR) ? RESP : WAIT;
      WAIT: if ((!pendL || hitL) && (!pendR || hitR)) stateNext = RESP;
      RESP: begin
        if (accept)                   stateNext = (resL && resR) ? RESP : WAIT;
        else if (opBus.i_RspFree_1)   stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= stateNext;
  end

  // Operand capture at accept time or when a waiting side resolves
  always_ff @(posedge clk) begin
    if (!rstn) begin
      pendL    <= 1'b0;
      pendR    <= 1'b0;
      tagL     <= NoDep;
      tagR     <= NoDep;
      operandL <= 32'd0;
      operandR <= 32'd0;
      srcL     <= 1'b0;
      srcR     <= 1'b0;
    end else if (accept) begin
      tagL  <= opBus.i_ReqDepL_4;
      tagR  <= opBus.i_ReqDepR_4;
      pendL <= !resL;
      pendR <= !resR;
      if (resL) begin
        operandL <= valL;
        srcL     <= (opBus.i_ReqDepL_4 != NoDep);
      end
      if (resR) begin
        operandR <= valR;
        srcR     <= (opBus.i_ReqDepR_4 != NoDep);
      end
    end else if (state == WAIT) begin
      if (pendL && hitL) begin
        operandL <= bypRdL;
        srcL     <= 1'b1;
        pendL    <= 1'b0;
      end
      if (pendR && hitR) begin
        operandR <= bypRdR;
        srcR     <= 1'b1;
        pendR    <= 1'b0;
      end
    end
  end

  // GRF storage; x0 is never written
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 32; i++) grf[i] <= 32'd0;
    end else if (i_GrfWe_1 && (i_GrfWaddr_5 != 5'd0)) begin
      grf[i_GrfWaddr_5] <= i_GrfWdata_32;
    end
  end

  // Bypass valid bits; a write beats a same-cycle release of the same tag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      bypValid <= 16'd0;
    end else begin
      if (i_BypRel_1 && (i_BypRelTag_4 != NoDep)) bypValid[i_BypRelTag_4] <= 1'b0;
      if (i_BypWe_1 && (i_BypTag_4 != NoDep))     bypValid[i_BypTag_4]    <= 1'b1;
    end
  end

  // Bypass data storage; contents only meaningful while valid
  always_ff @(posedge clk) begin
    if (i_BypWe_1 && (i_BypTag_4 != NoDep)) bypData[i_BypTag_4] <= i_BypData_32;
  end

`ifdef ALU_RSP_TIMEOUT_EN
  logic [7:0] waitCnt;
  logic       timeoutReg;

  // Saturating wait-cycle counter and sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rstn) begin
      waitCnt    <= 8'd0;
      timeoutReg <= 1'b0;
    end else begin
      if ((stateNext == WAIT) && (state != WAIT))       waitCnt <= 8'd0;
      else if ((state == WAIT) && (waitCnt != 8'hFF))   waitCnt <= waitCnt + 8'd1;
      if ((state == WAIT) && (waitCnt == 8'hFE))        timeoutReg <= 1'b1;
    end
  end

  assign o_Timeout_1 = timeoutReg;
`else
  assign o_Timeout_1 = 1'b0;
`endif

  assign opBus.o_ReqFree_1   = reqFree;
  assign opBus.o_RspDrive_1  = (state == RESP);
  assign opBus.o_OperandL_32 = operandL;
  assign opBus.o_OperandR_32 = operandR;
  assign opBus.o_SrcL_1      = srcL;
  assign opBus.o_SrcR_1      = srcR;

endmodule

// File: tb/tb_alu_operand_responder.sv
// Scoreboard bench for alu_operand_responder: a behavioural model pushes the
// expected operand pair when a request becomes fully resolved; a monitor on
// the falling edge compares the presented response against the queue head.
module tb_alu_operand_responder;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_operand_responder_if opBus ();

  logic        grfWe = 1'b0;
  logic [4:0]  grfWaddr = '0;
  logic [31:0] grfWdata = '0;
  logic        bypWe = 1'b0;
  logic [3:0]  bypTag = '0;
  logic [31:0] bypData = '0;
  logic        bypRel = 1'b0;
  logic [3:0]  bypRelTag = '0;
  logic        timeout;

  alu_operand_responder dut (
    .clk          (clk),
    .rstn         (rstn),
    .opBus        (opBus),
    .i_GrfWe_1    (grfWe),
    .i_GrfWaddr_5 (grfWaddr),
    .i_GrfWdata_32(grfWdata),
    .i_BypWe_1    (bypWe),
    .i_BypTag_4   (bypTag),
    .i_BypData_32 (bypData),
    .i_BypRel_1   (bypRel),
    .i_BypRelTag_4(bypRelTag),
    .o_Timeout_1  (timeout)
  );

  typedef struct packed {
    logic [31:0] l;
    logic [31:0] r;
    logic        sl;
    logic        sr;
  } rsp_t;

  rsp_t expQ[$];
  int   checks = 0;
  int   errors = 0;
  bit   monEn = 1'b0;

  // Behavioural model state: one outstanding request at most
  logic [31:0] mGrf [32];
  logic [15:0] mBV = '0;
  logic [31:0] mBD [16];
  bit          mBusy = 0, mReady = 0, mPendL = 0, mPendR = 0;
  logic [3:0]  mTagL = 4'hF, mTagR = 4'hF;
  logic [31:0] mL = '0, mR = '0;
  bit          mSL = 0, mSR = 0;
  int          mWaitLen = 0;
  bit          mTimeout = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] grfVal(input logic [4:0] idx);
    if (idx == 5'd0) return 32'd0;
    if (grfWe && grfWaddr == idx) return grfWdata;
    return mGrf[idx];
  endfunction

  function automatic bit bypAvail(input logic [3:0] t);
    if (t == 4'hF) return 1'b0;
    return (bypWe && bypTag == t) || mBV[t];
  endfunction

  function automatic logic [31:0] bypVal(input logic [3:0] t);
    if (bypWe && bypTag == t) return bypData;
    return mBD[t];
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mGrf[i] = '0;
    for (int i = 0; i < 16; i++) mBD[i] = '0;
  end

  // Reference model, evaluated on every rising edge from the applied inputs
  always @(posedge clk) begin : model
    bit free, wasWaiting;
    if (!rstn) begin
      for (int i = 0; i < 32; i++) mGrf[i] = '0;
      mBV = '0;
      mBusy = 0; mReady = 0; mPendL = 0; mPendR = 0;
      mWaitLen = 0; mTimeout = 0;
      expQ.delete();
    end else begin
      wasWaiting = mBusy && !mReady;
      free = !mBusy || (mReady && opBus.i_RspFree_1);
      if (mReady && opBus.i_RspFree_1) begin
        mBusy = 0;
        mReady = 0;
      end
      if (wasWaiting) begin
        if (mPendL && bypAvail(mTagL)) begin mL = bypVal(mTagL); mSL = 1; mPendL = 0; end
        if (mPendR && bypAvail(mTagR)) begin mR = bypVal(mTagR); mSR = 1; mPendR = 0; end
        if (!mPendL && !mPendR) begin
          mReady = 1;
          expQ.push_back(rsp_t'{mL, mR, mSL, mSR});
        end
        if (mWaitLen < 255) mWaitLen++;
`ifdef ALU_RSP_TIMEOUT_EN
        if (mWaitLen == 255) mTimeout = 1;
`endif
      end
      if (free && opBus.i_ReqDrive_1) begin
        mBusy = 1;
        mReady = 0;
        mTagL = opBus.i_ReqDepL_4;
        mTagR = opBus.i_ReqDepR_4;
        mPendL = 0;
        mPendR = 0;
        if (mTagL == 4'hF)        begin mL = grfVal(opBus.i_ReqRs1_5); mSL = 0; end
        else if (bypAvail(mTagL)) begin mL = bypVal(mTagL); mSL = 1; end
        else                      mPendL = 1;
        if (mTagR == 4'hF)        begin mR = grfVal(opBus.i_ReqRs2_5); mSR = 0; end
        else if (bypAvail(mTagR)) begin mR = bypVal(mTagR); mSR = 1; end
        else                      mPendR = 1;
        if (!mPendL && !mPendR) begin
          mReady = 1;
          expQ.push_back(rsp_t'{mL, mR, mSL, mSR});
        end else begin
          mWaitLen = 0;
        end
      end
      if (grfWe && grfWaddr != 5'd0) mGrf[grfWaddr] = grfWdata;
      if (bypRel && bypRelTag != 4'hF) mBV[bypRelTag] = 1'b0;
      if (bypWe && bypTag != 4'hF) begin
        mBV[bypTag] = 1'b1;
        mBD[bypTag] = bypData;
      end
    end
  end

  // Monitor: handshake outputs every cycle, operand pair against queue head
  always @(negedge clk) begin
    if (monEn) begin
      chk("reqFree", {31'd0, opBus.o_ReqFree_1},
          {31'd0, rstn && (!mBusy || (mReady && opBus.i_RspFree_1))});
      chk("rspDrive", {31'd0, opBus.o_RspDrive_1}, {31'd0, mReady});
      chk("timeout", {31'd0, timeout}, {31'd0, mTimeout});
      if (opBus.o_RspDrive_1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rspUnexpected: response presented with empty scoreboard (t=%0t)", $time);
        end else begin
          chk("operandL", opBus.o_OperandL_32, expQ[0].l);
          chk("operandR", opBus.o_OperandR_32, expQ[0].r);
          chk("srcL", {31'd0, opBus.o_SrcL_1}, {31'd0, expQ[0].sl});
          chk("srcR", {31'd0, opBus.o_SrcR_1}, {31'd0, expQ[0].sr});
          if (opBus.i_RspFree_1) void'(expQ.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    grfWe = 0;
    bypWe = 0;
    bypRel = 0;
    opBus.i_ReqDrive_1 = 0;
  endtask

  task automatic req(input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [3:0] depL, input logic [3:0] depR);
    opBus.i_ReqDrive_1 = 1;
    opBus.i_ReqRs1_5   = rs1;
    opBus.i_ReqRs2_5   = rs2;
    opBus.i_ReqDepL_4  = depL;
    opBus.i_ReqDepR_4  = depR;
  endtask

  initial begin
    opBus.i_ReqDrive_1 = 0;
    opBus.i_ReqRs1_5   = '0;
    opBus.i_ReqRs2_5   = '0;
    opBus.i_ReqDepL_4  = 4'hF;
    opBus.i_ReqDepR_4  = 4'hF;
    opBus.i_RspFree_1  = 1;

    // Reset
    tick();
    monEn = 1'b1;
    tick();
    tick();
    chk("rstOperandL", opBus.o_OperandL_32, 32'd0);
    chk("rstOperandR", opBus.o_OperandR_32, 32'd0);
    chk("rstSrc", {30'd0, opBus.o_SrcL_1, opBus.o_SrcR_1}, 32'd0);
    chk("rstReqFree", {31'd0, opBus.o_ReqFree_1}, 32'd0);
    rstn = 1;
    tick();

    // GRF sourced operands
    grfWe = 1; grfWaddr = 5; grfWdata = 32'h1111_2222;
    tick();
    grfWaddr = 7; grfWdata = 32'hA5A5_0000;
    tick();
    clr();
    req(5, 7, 4'hF, 4'hF);
    tick();
    clr();
    tick();
    tick();

    // x0 reads zero despite a write
    grfWe = 1; grfWaddr = 0; grfWdata = 32'hFFFF_FFFF;
    tick();
    clr();
    req(0, 5, 4'hF, 4'hF);
    tick();
    clr();
    tick();

    // GRF write-through to a same-cycle read
    grfWe = 1; grfWaddr = 9; grfWdata = 32'h0BAD_F00D;
    req(9, 9, 4'hF, 4'hF);
    tick();
    clr();
    tick();

    // Dependency wait on invalid entry 3, then bypass write forwards
    bypRel = 1; bypRelTag = 3;
    tick();
    clr();
    req(1, 7, 4'd3, 4'hF);
    tick();
    clr();
    repeat (10) tick();
    bypWe = 1; bypTag = 3; bypData = 32'hDEAD_BEEF;
    tick();
    clr();
    tick();
    tick();

    // Held response with GRF writes underneath, then back-to-back transfer
    opBus.i_RspFree_1 = 0;
    req(5, 7, 4'hF, 4'hF);
    tick();
    clr();
    for (int i = 0; i < 5; i++) begin
      grfWe = 1; grfWaddr = 5; grfWdata = $urandom;
      tick();
    end
    clr();
    opBus.i_RspFree_1 = 1;
    req(7, 5, 4'hF, 4'hF);
    tick();
    clr();
    tick();
    tick();

    // Bypass write and release of the same tag: write wins
    bypWe = 1; bypTag = 2; bypData = 32'h2222_CAFE;
    bypRel = 1; bypRelTag = 2;
    tick();
    clr();
    req(3, 4, 4'hF, 4'd2);
    tick();
    clr();
    tick();

    // Both sides on the same tag, and ignored writes to tag 15
    bypRel = 1; bypRelTag = 4;
    tick();
    clr();
    req(0, 0, 4'd4, 4'd4);
    tick();
    clr();
    bypWe = 1; bypTag = 4'hF; bypData = 32'h5555_5555;
    tick();
    bypTag = 4; bypData = 32'h4444_0004;
    tick();
    clr();
    tick();
    tick();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      opBus.i_RspFree_1 = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1)
        req($urandom_range(0, 31), $urandom_range(0, 31),
            ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 3)),
            ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 3)));
      else
        opBus.i_ReqDrive_1 = 0;
      grfWe = ($urandom_range(0, 2) == 0);
      grfWaddr = $urandom_range(0, 31);
      grfWdata = $urandom;
      bypWe = ($urandom_range(0, 3) == 0);
      bypTag = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      bypData = $urandom;
      bypRel = ($urandom_range(0, 4) == 0);
      bypRelTag = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      tick();
    end
    clr();
    opBus.i_RspFree_1 = 1;
    for (int t = 0; t < 4; t++) begin
      bypWe = 1; bypTag = 4'(t); bypData = $urandom;
      tick();
    end
    clr();
    repeat (4) tick();

    // Long wait (timeout when enabled), then reset drops the request
    bypRel = 1; bypRelTag = 9;
    tick();
    clr();
    req(2, 3, 4'd9, 4'hF);
    tick();
    clr();
    repeat (300) tick();
    rstn = 0;
    tick();
    rstn = 1;
    chk("timeoutAfterReset", {31'd0, timeout}, 32'd0);
    chk("rspDriveAfterReset", {31'd0, opBus.o_RspDrive_1}, 32'd0);
    repeat (3) tick();
    chk("scoreboardDrained", expQ.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
